// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and the load/store unit types.
//   XLEN                 data/address width (32 only)
//   F3_LOAD_* / F3_STORE_* funct3 encodings for LOAD / STORE
//   lsu_state_e          LSU sequencer states
//   lsu_err_e            LSU response error codes
//   LSU_TIMEOUT_DEFAULT  default WAIT-state timeout in cycles
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LOAD_LB  = 3'b000;
    localparam logic [2:0] F3_LOAD_LH  = 3'b001;
    localparam logic [2:0] F3_LOAD_LW  = 3'b010;
    localparam logic [2:0] F3_LOAD_LBU = 3'b100;
    localparam logic [2:0] F3_LOAD_LHU = 3'b101;

    localparam logic [2:0] F3_STORE_SB = 3'b000;
    localparam logic [2:0] F3_STORE_SH = 3'b001;
    localparam logic [2:0] F3_STORE_SW = 3'b010;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_OK       = 2'b00,
        LSU_MISALIGN = 2'b01,
        LSU_BUSERR   = 2'b10,
        LSU_TIMEOUT  = 2'b11
    } lsu_err_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational access-size decode for the load/store unit.
//   is_store_i  1 = store, 0 = load
//   funct3_i    instruction funct3
//   addr_lo_i   byte offset within the word
//   wdata_i     raw store data (rs2)
//   rdata_i     raw bus read word
//   be_o        byte enables for the access
//   legal_o     funct3 is a valid encoding for the access kind
//   aligned_o   address is naturally aligned for the access size
//   wdata_o     store data replicated across all byte lanes
//   rdata_o     load data shifted down and sign/zero extended
module lsu_align
    import riscv_pkg::*;
(
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic            legal_o,
    output logic            aligned_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o      = 4'b1111;
        aligned_o = 1'b1;
        wdata_o   = wdata_i;
        // funct3[1:0] encodes the size for both loads and stores.
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o   = {2{wdata_i[15:0]}};
                aligned_o = ~addr_lo_i[0];
            end
            2'b10:   aligned_o = (addr_lo_i == 2'b00);
            default: aligned_o = 1'b1;
        endcase
    end

    always_comb begin
        if (is_store_i)
            legal_o = (funct3_i == F3_STORE_SB) || (funct3_i == F3_STORE_SH) ||
                      (funct3_i == F3_STORE_SW);
        else
            legal_o = (funct3_i == F3_LOAD_LB)  || (funct3_i == F3_LOAD_LH) ||
                      (funct3_i == F3_LOAD_LW)  || (funct3_i == F3_LOAD_LBU) ||
                      (funct3_i == F3_LOAD_LHU);
    end

    always_comb begin
        case (funct3_i)
            F3_LOAD_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LOAD_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LOAD_LW:  rdata_o = rdata_i;
            F3_LOAD_LBU: rdata_o = {24'd0, shifted[7:0]};
            F3_LOAD_LHU: rdata_o = {16'd0, shifted[15:0]};
            default:     rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences RV32I loads/stores onto a single-outstanding
// data bus and returns one response per request.
//   clk / rst_n        clock, asynchronous active-low reset
//   req_*              execute-stage request (valid/ready, kind, funct3, addr, data, rd)
//   rsp_*              response (valid/ready, extended rdata, rd, error code)
//   bus_*              data-memory bus: req/gnt address phase, rvalid/err data phase
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN           = riscv_pkg::XLEN,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_is_store_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic [4:0]      rsp_rd_o,
    output logic [1:0]      rsp_err_o,
    output logic            bus_req_o,
    input  logic            bus_gnt_i,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [3:0]      bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    input  logic            bus_err_i
);

    lsu_state_e      state_q, state_d;
    lsu_err_e        err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            in_idle;
    logic            a_is_store;
    logic [2:0]      a_funct3;
    logic [1:0]      a_addr_lo;
    logic [XLEN-1:0] a_wdata;
    logic [3:0]      a_be;
    logic            a_legal, a_aligned;
    logic [XLEN-1:0] a_wdata_rep, a_rdata_ext;
    logic [7:0]      cnt_inc;

    // One decoder serves both the IDLE legality check (live request) and
    // the later bus/format phases (latched request).
    assign in_idle    = (state_q == IDLE);
    assign a_is_store = in_idle ? req_is_store_i : is_store_q;
    assign a_funct3   = in_idle ? req_funct3_i : funct3_q;
    assign a_addr_lo  = in_idle ? req_addr_i[1:0] : addr_q[1:0];
    assign a_wdata    = in_idle ? req_wdata_i : wdata_q;

    lsu_align u_align (
        .is_store_i (a_is_store),
        .funct3_i   (a_funct3),
        .addr_lo_i  (a_addr_lo),
        .wdata_i    (a_wdata),
        .rdata_i    (bus_rdata_i),
        .be_o       (a_be),
        .legal_o    (a_legal),
        .aligned_o  (a_aligned),
        .wdata_o    (a_wdata_rep),
        .rdata_o    (a_rdata_ext)
    );

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    is_store_d = req_is_store_i;
                    funct3_d   = req_funct3_i;
                    addr_d     = req_addr_i;
                    wdata_d    = req_wdata_i;
                    rd_d       = req_rd_i;
                    rdata_d    = '0;
                    if (a_legal && a_aligned) begin
                        state_d = ADDR;
                        err_d   = LSU_OK;
                    end else begin
                        state_d = RESP;
                        err_d   = LSU_MISALIGN;
                    end
                end
            end
            ADDR: begin
                if (bus_gnt_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // rvalid takes priority over a timeout in the same cycle.
                if (bus_rvalid_i) begin
                    state_d = RESP;
                    if (bus_err_i) begin
                        err_d   = LSU_BUSERR;
                        rdata_d = '0;
                    end else begin
                        err_d   = LSU_OK;
                        rdata_d = is_store_q ? '0 : a_rdata_ext;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(TIMEOUT_CYCLES)) begin
                        state_d = RESP;
                        err_d   = LSU_TIMEOUT;
                        rdata_d = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= LSU_OK;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs are gated by state so everything outside its phase reads 0.
    assign req_ready_o = in_idle;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_rd_o    = (rsp_valid_o && !is_store_q) ? rd_q : 5'd0;
    assign rsp_err_o   = rsp_valid_o ? err_q : 2'b00;

    assign bus_req_o   = (state_q == ADDR);
    assign bus_we_o    = bus_req_o && is_store_q;
    assign bus_addr_o  = bus_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign bus_be_o    = bus_req_o ? a_be : 4'b0000;
    assign bus_wdata_o = bus_req_o ? a_wdata_rep : '0;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_is_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  rsp_err_o;
    logic        bus_req_o, bus_gnt_i, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
    logic        bus_rvalid_i, bus_err_i;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_is_store_i(req_is_store_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    // Slave configuration (written by the stimulus thread only).
    int          s_gnt_cyc = 1;
    bit          s_never   = 1'b0;
    bit          s_err     = 1'b0;
    logic [31:0] s_rdata   = 32'h0;
    int          late_req  = 0;
    // Slave-owned state.
    int          late_done = 0;
    int          req_cyc   = 0;
    int          rv_cnt    = 0;
    int          last_req_cyc = 0;

    // Bus slave: grants after s_gnt_cyc request cycles, answers the cycle
    // after the grant (unless s_never), and checks the address phase.
    initial begin
        bus_t b;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0; bus_rdata_i = 0;
        forever begin
            @(posedge clk); #1;
            bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0; bus_rdata_i = 0;
            if (late_req != late_done) begin
                late_done = late_req;
                bus_rvalid_i = 1; bus_rdata_i = 32'hBAD0BAD0;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus_rvalid_i = 1; bus_err_i = s_err; bus_rdata_i = s_rdata;
                end
            end else if (bus_req_o) begin
                req_cyc++;
                if (req_cyc >= s_gnt_cyc) begin
                    bus_gnt_i = 1;
                    last_req_cyc = req_cyc;
                    req_cyc = 0;
                    rv_cnt = s_never ? 0 : 1;
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_we", {31'd0, bus_we_o}, {31'd0, b.we});
                        check("bus_addr", bus_addr_o, b.addr);
                        check("bus_be", {28'd0, bus_be_o}, {28'd0, b.be});
                        if (b.we) check("bus_wdata", bus_wdata_o, b.wdata);
                    end
                end
            end
        end
    end

    task automatic send(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                        input int exp_lat, input int hold);
        rsp_t e;
        int   lat;
        bit   got;
        if (exp_err != 2'b01) bus_q.push_back('{we: st, addr: {a[31:2], 2'b00}, be: exp_be, wdata: exp_wd});
        rsp_q.push_back('{rdata: exp_rdata, rd: st ? 5'd0 : rd, err: exp_err, lat: exp_lat});
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1; req_is_store_i = st; req_funct3_i = f3;
        req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
        @(posedge clk); #1;
        req_valid_i = 0;
        lat = 0; got = 0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_o) got = 1;
        end
        e = rsp_q.pop_front();
        if (!got) begin
            check("rsp_never_came", 32'd0, 32'd1);
            return;
        end
        check("rsp_latency", lat, e.lat);
        check("rsp_rdata", rsp_rdata_o, e.rdata);
        check("rsp_rd", {27'd0, rsp_rd_o}, {27'd0, e.rd});
        check("rsp_err", {30'd0, rsp_err_o}, {30'd0, e.err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("hold_rdata", rsp_rdata_o, e.rdata);
            check("hold_err", {30'd0, rsp_err_o}, {30'd0, e.err});
        end
        rsp_ready_i = 1;
        @(posedge clk); #1;
        rsp_ready_i = 0;
        check("back_to_idle", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        rst_n = 0; req_valid_i = 0; req_is_store_i = 0; req_funct3_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0; rsp_ready_i = 0;
        #3;
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        check("rst_bus_be", {28'd0, bus_be_o}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // LW basic, minimum latency
        s_rdata = 32'hDEADBEEF;
        send(0, 3'b010, 32'h100, 32'h0, 5'd3, 4'b1111, 32'h0, 32'hDEADBEEF, 2'b00, 3, 0);
        // LB / LBU top byte
        s_rdata = 32'h80112233;
        send(0, 3'b000, 32'h103, 32'h0, 5'd4, 4'b1000, 32'h0, 32'hFFFFFF80, 2'b00, 3, 0);
        send(0, 3'b100, 32'h103, 32'h0, 5'd4, 4'b1000, 32'h0, 32'h00000080, 2'b00, 3, 0);
        // LH / LHU upper half
        s_rdata = 32'h80011234;
        send(0, 3'b001, 32'h102, 32'h0, 5'd8, 4'b1100, 32'h0, 32'hFFFF8001, 2'b00, 3, 0);
        send(0, 3'b101, 32'h102, 32'h0, 5'd8, 4'b1100, 32'h0, 32'h00008001, 2'b00, 3, 0);
        // SH with grant on the 4th request cycle
        s_gnt_cyc = 4; s_rdata = 32'h55555555;
        send(1, 3'b001, 32'h102, 32'h0000ABCD, 5'd9, 4'b1100, 32'hABCDABCD, 32'h0, 2'b00, 6, 0);
        check("sh_req_cycles", last_req_cyc, 32'd4);
        s_gnt_cyc = 1;
        // SB lane 1
        send(1, 3'b000, 32'h201, 32'h12345678, 5'd1, 4'b0010, 32'h78787878, 32'h0, 2'b00, 3, 0);
        // Misaligned LW, illegal store funct3
        send(0, 3'b010, 32'h101, 32'h0, 5'd5, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
        check("misalign_no_bus", {31'd0, bus_req_o}, 32'd0);
        send(1, 3'b011, 32'h200, 32'h1, 5'd6, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);

        // Timeout: 1 ADDR + 8 WAIT cycles, then a late rvalid must be ignored
        s_never = 1;
        send(0, 3'b010, 32'h400, 32'h0, 5'd7, 4'b1111, 32'h0, 32'h0, 2'b11, 10, 0);
        s_never = 0;
        late_req++;
        repeat (3) @(negedge clk);
        check("late_rvalid_ignored", {31'd0, rsp_valid_o}, 32'd0);
        s_rdata = 32'h01234567;
        send(0, 3'b010, 32'h104, 32'h0, 5'd10, 4'b1111, 32'h0, 32'h01234567, 2'b00, 3, 0);

        // Reset in WAIT
        s_never = 1;
        bus_q.push_back('{we: 1'b0, addr: 32'h600, be: 4'b1111, wdata: 32'h0});
        @(negedge clk);
        req_valid_i = 1; req_is_store_i = 0; req_funct3_i = 3'b010;
        req_addr_i = 32'h600; req_rd_i = 5'd11;
        @(posedge clk); #1;
        req_valid_i = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready_o}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("midrst_bus_req", {31'd0, bus_req_o}, 32'd0);
        check("midrst_rsp_rd", {27'd0, rsp_rd_o}, 32'd0);
        @(negedge clk);
        rst_n = 1; s_never = 0;
        late_req++;
        repeat (3) @(negedge clk);
        check("postrst_rvalid_ignored", {31'd0, rsp_valid_o}, 32'd0);

        // Bus error with a stalled consumer
        s_err = 1; s_rdata = 32'h11111111;
        send(0, 3'b010, 32'h500, 32'h0, 5'd12, 4'b1111, 32'h0, 32'h0, 2'b10, 3, 5);
        s_err = 0;

        repeat (2) @(negedge clk);
        check("bus_queue_drained", bus_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", checks);
        $fatal(1);
    end

endmodule
